// File: rtl/issue_sched_pkg.sv
// Shared decode types for the instruction queue / issue scheduler.
// pipe_id_t is the decoder-to-issue record; issue_slot_t adds the delay-slot tag.
package inst_decode;

  localparam int ISSUE_SCHED_DEPTH = 8;

  typedef struct packed {
    logic       is_controlflow;
    logic [3:0] op;
  } decode_resp_t;

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    decode_resp_t decode_resp;
  } pipe_id_t;

  typedef struct packed {
    pipe_id_t id;
    logic     is_delayslot;
  } issue_slot_t;

  typedef enum logic {ISS_NORMAL, ISS_DS_PENDING} iss_fsm_t;

endpackage

// File: rtl/issue_sched_select.sv
// Combinational issue-slot selection: in-order offer, delay-slot hold rule,
// delay-slot tagging and stall_ds.
module issue_sched_select
  import inst_decode::*;
#(
  parameter int N_ISSUE = 2,
  parameter int DEPTH   = ISSUE_SCHED_DEPTH
) (
  input  pipe_id_t    [N_ISSUE-1:0]         cand,
  input  logic        [$clog2(DEPTH):0]     count,
  input  logic                              ds_pending,
  output issue_slot_t [N_ISSUE-1:0]         slot,
  output logic        [$clog2(N_ISSUE+1)-1:0] n_valid,
  output logic                              stall_ds
);

  localparam int NW = $clog2(N_ISSUE+1);

  always_comb begin
    logic run;
    int   cnt;
    slot    = '0;
    n_valid = '0;
    run     = 1'b1;
    cnt     = int'(count);
    for (int k = 0; k < N_ISSUE; k++) begin
      slot[k].id       = cand[k];
      slot[k].id.valid = 1'b0;
      // a control-flow op may only leave together with (or after) its delay slot
      if (run && k < cnt && (!cand[k].decode_resp.is_controlflow || cnt > k + 1)) begin
        slot[k].id.valid = 1'b1;
        n_valid          = n_valid + NW'(1);
      end else begin
        run = 1'b0;
      end
    end
    slot[0].is_delayslot = slot[0].id.valid && ds_pending;
    for (int k = 1; k < N_ISSUE; k++)
      slot[k].is_delayslot = slot[k].id.valid && slot[k-1].id.valid &&
                             slot[k-1].id.decode_resp.is_controlflow;
    stall_ds = (cnt == 1) && cand[0].decode_resp.is_controlflow;
  end

endmodule

// File: rtl/issue_sched.sv
// Instruction queue + in-order issue scheduler with MIPS delay-slot handling.
// Define ISSUE_SCHED_PERF_EN to add saturating perf_ds_stall / perf_full counters.
module issue_sched
  import inst_decode::*;
#(
  parameter int N_ISSUE = 2,
  parameter int DEPTH   = ISSUE_SCHED_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  pipe_id_t [N_ISSUE-1:0]     enq_id,
  output logic                       enq_ready,
  output pipe_id_t [N_ISSUE-1:0]     iss_id,
  output logic     [N_ISSUE-1:0]     iss_delayslot,
  input  logic                       iss_ready,
  output logic                       stall_ds,
  output logic     [$clog2(DEPTH):0] occupancy
`ifdef ISSUE_SCHED_PERF_EN
  ,
  output logic     [31:0]            perf_ds_stall,
  output logic     [31:0]            perf_full
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(N_ISSUE+1);

  pipe_id_t                mem [DEPTH];
  logic        [PW-1:0]    head, tail;
  logic        [CW-1:0]    count;
  iss_fsm_t                state, state_nxt;
  pipe_id_t    [N_ISSUE-1:0] cand;
  issue_slot_t [N_ISSUE-1:0] slot;
  logic        [NW-1:0]    n_valid, n_enq;

  // space is judged on registered count only; same-cycle issue frees nothing
  assign enq_ready = (count <= CW'(DEPTH - N_ISSUE));
  assign occupancy = count;

  always_comb begin
    n_enq = '0;
    for (int i = 0; i < N_ISSUE; i++)
      if (enq_id[i].valid) n_enq = n_enq + NW'(1);
  end

  always_comb begin
    cand = '0;
    for (int k = 0; k < N_ISSUE; k++) cand[k] = mem[head + PW'(k)];
  end

  issue_sched_select #(.N_ISSUE(N_ISSUE), .DEPTH(DEPTH)) u_select (
    .cand       (cand),
    .count      (count),
    .ds_pending (state == ISS_DS_PENDING),
    .slot       (slot),
    .n_valid    (n_valid),
    .stall_ds   (stall_ds)
  );

  always_comb begin
    for (int k = 0; k < N_ISSUE; k++) begin
      iss_id[k]        = slot[k].id;
      iss_delayslot[k] = slot[k].is_delayslot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && enq_ready)
      for (int i = 0; i < N_ISSUE; i++)
        if (enq_id[i].valid) mem[tail + PW'(i)] <= enq_id[i];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_ready) tail <= tail + PW'(n_enq);
      if (iss_ready) head <= head + PW'(n_valid);
      count <= count + (enq_ready ? CW'(n_enq) : '0) - (iss_ready ? CW'(n_valid) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ISS_NORMAL;
    else     state <= state_nxt;
  end

  // a branch leaving in the last slot leaves its delay slot as the next head
  always_comb begin
    state_nxt = state;
    if (flush)
      state_nxt = ISS_NORMAL;
    else if (iss_ready && n_valid != '0)
      state_nxt = (slot[N_ISSUE-1].id.valid && slot[N_ISSUE-1].id.decode_resp.is_controlflow)
                  ? ISS_DS_PENDING : ISS_NORMAL;
  end

`ifdef ISSUE_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ds_stall <= '0;
      perf_full     <= '0;
    end else begin
      if (stall_ds && perf_ds_stall != '1) perf_ds_stall <= perf_ds_stall + 32'd1;
      if (count == CW'(DEPTH) && perf_full != '1) perf_full <= perf_full + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < N_ISSUE; i++)
        assert (!enq_id[i].valid || enq_id[i-1].valid);
      assert (state != ISS_DS_PENDING || count != '0);
    end
  end

endmodule

// File: doc/issue_sched.md
Name: issue_sched

Overview:
- Instruction queue and issue scheduler between the decoder output (pipe_id_t) and the issue/execute stage.
- Buffers up to DEPTH decoded instructions and issues up to N_ISSUE per cycle in program order.
- Enforces the MIPS delay-slot rule: a control-flow instruction leaves the queue only when its delay slot is already buffered.
- Tags each issued instruction with an is_delayslot flag.

Parameters:
- N_ISSUE, 2, instructions enqueued and issued per cycle (≥1).
- DEPTH, 8, queue entries; power of two, ≥ 2*N_ISSUE.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush, same source as pipe_ifid flush
- enq_id  in  N_ISSUE x pipe_id_t  decoded instructions; slot i is valid when enq_id[i].valid
- enq_ready  out  1  queue can accept a full N_ISSUE group this cycle
- iss_id  out  N_ISSUE x pipe_id_t  instructions offered to issue
- iss_delayslot  out  N_ISSUE  slot i is the delay slot of a control-flow instruction
- iss_ready  in  1  downstream takes every valid iss_id slot this cycle
- stall_ds  out  1  head-group issue is blocked waiting for a delay slot
- occupancy  out  $clog2(DEPTH)+1  current entry count

Behaviour:
- Storage: circular buffer with head/tail pointers that wrap modulo DEPTH, plus a count register. occupancy = count.
- Reset / flush: count=0, head=tail=0, ds_pending=0. Outputs after reset: enq_ready=1, all iss_id[i].valid=0, iss_delayslot=0, stall_ds=0. Flush has priority over same-cycle enqueue and issue; both are dropped.
- Enqueue:
  - Valid enq slots are contiguous from slot 0. A non-contiguous pattern is illegal and is covered by an assertion.
  - enq_ready = (DEPTH - count ≥ N_ISSUE), computed from registered count only. Same-cycle issue does not free space for enqueue.
  - When enq_ready=1, every valid slot is written at tail, tail+1, ... in order. When enq_ready=0, input is ignored; the upstream holds its group.
- Issue selection (combinational from queue state), for k = 0..N_ISSUE-1 in order:
  - Candidate slot k is entry head+k. It is offered if k < count and all earlier slots were offered.
  - If candidate k is control-flow (decode_resp.is_controlflow), it is offered only if count > k+1, i.e. its delay slot is buffered. Otherwise slot k and all later slots are invalid.
  - stall_ds=1 when slot 0 is withheld by this rule (head is control-flow and count==1).
- iss_delayslot:
  - Slot 0 = ds_pending.
  - Slot k>0 = slot k-1 is valid and control-flow.
  - Zero for invalid slots.
- Handshake: when iss_ready=1, head advances by the number of valid slots and count updates by (enqueued − issued) in the same cycle. When iss_ready=0, queue state and offers are held stable.
- FSM with one bit, ds_pending:
  - NORMAL → DS_PENDING: a control-flow instruction is issued in slot N_ISSUE-1 with iss_ready=1.
  - DS_PENDING → NORMAL: on the next accepted issue.
  - In DS_PENDING the head is guaranteed to be the delay slot, because it was buffered when the branch left. Assertion: count ≥ 1 while ds_pending.
  - flush/rst force NORMAL.
- Back-to-back control flow (a delay slot that is itself control-flow, which is architecturally UNPREDICTABLE) gets no special handling. It is tagged both delay slot and control flow and follows the same rules.
- Full: count==DEPTH → enq_ready=0. Empty: no valid iss slots, stall_ds=0.
- Latency: an instruction enqueued in cycle t can issue no earlier than cycle t+1.

Optional Feature:
- ISSUE_SCHED_PERF_EN defined: adds 32-bit saturating counters perf_ds_stall (cycles with stall_ds=1) and perf_full (cycles with count==DEPTH), exported as output ports. Both are cleared by rst only, not by flush.
- ISSUE_SCHED_PERF_EN undefined: ports and logic are absent.

Decomposition:
- Package inst_decode (inst_decode.svh) gains:
  - ISSUE_SCHED_DEPTH default constant.
  - issue_slot_t {pipe_id_t id; logic is_delayslot;}.
  - iss_fsm_t enum {ISS_NORMAL, ISS_DS_PENDING}.
- One natural sub-module, issue_sched_select: the combinational slot selection, delay-slot tagging and stall_ds logic. The top level keeps storage, pointers and the FSM.

Test Plan (N_ISSUE=2, DEPTH=8):
- Reset, then enqueue two ALU ops → next cycle both slots valid, iss_delayslot=00, occupancy 2→0 after iss_ready.
- Enqueue a branch alone, hold 3 cycles → stall_ds=1, no valid iss slots. Then enqueue its delay slot → next cycle branch in slot 0, delay slot in slot 1, iss_delayslot=10 (slot1 set).
- Enqueue ALU, branch, DS → cycle 1 issues ALU+branch (slot1 branch, count 3>2) and enters DS_PENDING; cycle 2 issues DS in slot 0 with iss_delayslot[0]=1, FSM returns to NORMAL.
- Fill to count 8 with iss_ready=0 → enq_ready=0 and input ignored. Raise iss_ready → count 8→6 and enq_ready returns to 1 the cycle after.
- Flush while in DS_PENDING with simultaneous enqueue → next cycle count=0, ds_pending=0, enqueue dropped, iss_delayslot=00.
- Wrap-around: 20 cycles of enqueue-2/issue-2 with iss_ready toggling → program order preserved across pointer wrap, verified by a scoreboard.
